// File: rtl/press_pkg.sv
// Shared encodings and widths for the press sequence detector.
package press_pkg;

  localparam int ST_W   = 2;
  localparam int HIST_W = 4;
  localparam int CNT_W  = 3;
  localparam int CTR_W  = 8;

  localparam logic [ST_W-1:0]  ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0]  ST_HELD = 2'd1;
  localparam logic [ST_W-1:0]  ST_GAP  = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX = 3'd4;

  typedef enum logic [ST_W-1:0] {
    IDLE = ST_IDLE,
    HELD = ST_HELD,
    GAP  = ST_GAP
  } state_t;

  // Symbol count saturates once a full four-symbol window is available.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/press_timer.sv
// Press FSM: measures hold duration and inter-press gap, flags release and gap timeout.
module press_timer
  import press_pkg::*;
#(
  parameter int LONG_CYC = 8,
  parameter int GAP_CYC  = 16
) (
  input  logic CLK,
  input  logic reset_n,
  input  logic clean,
  output logic rel_pulse,
  output logic long_press,
  output logic timeout
);

  localparam logic [CTR_W-1:0] LONG_V   = CTR_W'(LONG_CYC);
  localparam logic [CTR_W-1:0] GAP_LAST = CTR_W'(GAP_CYC - 1);

  state_t           state;
  logic [CTR_W-1:0] dur;
  logic [CTR_W-1:0] gap;

  // Release and timeout are decided on the sampling edge itself so the top
  // can register PRESS/MATCH with a single cycle of latency.
  assign rel_pulse  = (state == HELD) && !clean;
  assign long_press = (dur >= LONG_V);
  assign timeout    = (state == GAP) && !clean && ((gap + CTR_W'(1)) == GAP_LAST);

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state <= IDLE;
      dur   <= '0;
      gap   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clean) begin
            state <= HELD;
            dur   <= CTR_W'(1);
          end
        end
        HELD: begin
          if (clean) begin
            if (dur < LONG_V) dur <= dur + CTR_W'(1);
          end else begin
            state <= GAP;
            gap   <= '0;
          end
        end
        GAP: begin
          if (clean) begin
            state <= HELD;
            dur   <= CTR_W'(1);
          end else begin
            gap <= gap + CTR_W'(1);
            if (timeout) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/press_seq_detector.sv
// Classifies button presses as short/long and pulses MATCH when the last four equal PATTERN.
module press_seq_detector
  import press_pkg::*;
#(
  parameter int                LONG_CYC = 8,
  parameter int                GAP_CYC  = 16,
  parameter logic [HIST_W-1:0] PATTERN  = 4'b1101
) (
  input  logic CLK,
  input  logic reset_n,
  input  logic CLEAN,
  output logic PRESS,
  output logic SYM,
  output logic MATCH
);

  logic              rel_pulse;
  logic              long_press;
  logic              timeout;
  logic [HIST_W-1:0] hist;
  logic [HIST_W-1:0] hist_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;

  press_timer #(
    .LONG_CYC (LONG_CYC),
    .GAP_CYC  (GAP_CYC)
  ) u_timer (
    .CLK        (CLK),
    .reset_n    (reset_n),
    .clean      (CLEAN),
    .rel_pulse  (rel_pulse),
    .long_press (long_press),
    .timeout    (timeout)
  );

  assign hist_nxt = {hist[HIST_W-2:0], long_press};
  assign cnt_nxt  = sat_inc(cnt);

  // History is kept across matches so overlapping windows are detected.
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      hist  <= '0;
      cnt   <= '0;
      PRESS <= 1'b0;
      SYM   <= 1'b0;
      MATCH <= 1'b0;
    end else begin
      PRESS <= rel_pulse;
      MATCH <= 1'b0;
      if (rel_pulse) begin
        hist  <= hist_nxt;
        cnt   <= cnt_nxt;
        SYM   <= long_press;
        MATCH <= (cnt_nxt == CNT_MAX) && (hist_nxt == PATTERN);
      end else if (timeout) begin
        hist <= '0;
        cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_press_seq_detector.sv
// Directed bench for press_seq_detector (LONG_CYC=8, GAP_CYC=16, PATTERN=1101).
module tb_press_seq_detector;

  logic CLK     = 1'b0;
  logic reset_n = 1'b0;
  logic CLEAN   = 1'b0;
  logic PRESS, SYM, MATCH;

  int   vecs = 0;
  int   errs = 0;
  logic last_sym = 1'b0;

  press_seq_detector #(
    .LONG_CYC (8),
    .GAP_CYC  (16),
    .PATTERN  (4'b1101)
  ) dut (
    .CLK     (CLK),
    .reset_n (reset_n),
    .CLEAN   (CLEAN),
    .PRESS   (PRESS),
    .SYM     (SYM),
    .MATCH   (MATCH)
  );

  always #5 CLK = ~CLK;

  // Compares {PRESS,SYM,MATCH}.
  task automatic chk(input string tag, input logic [2:0] exp);
    logic [2:0] obs;
    obs = {PRESS, SYM, MATCH};
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed PSM=%b expected PSM=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic c, input logic r = 1'b1);
    CLEAN   = c;
    reset_n = r;
    @(posedge CLK);
    #1;
  endtask

  // Hold for n cycles, then release; check the cycle after the release edge.
  task automatic press(input string tag, input int n, input logic sym, input logic m);
    for (int i = 0; i < n; i++) step(1'b1);
    chk({tag, "_hold"}, {1'b0, last_sym, 1'b0});
    step(1'b0);
    chk({tag, "_rel"}, {1'b1, sym, m});
    last_sym = sym;
  endtask

  // g = total released cycles counting the release sample itself (g >= 2).
  task automatic gap(input string tag, input int g);
    for (int i = 1; i < g; i++) step(1'b0);
    chk({tag, "_gap"}, {1'b0, last_sym, 1'b0});
  endtask

  task automatic do_reset(input string tag, input logic c);
    step(c, 1'b0);
    chk({tag, "_rst"}, 3'b000);
    last_sym = 1'b0;
  endtask

  initial begin
    // Power-on reset
    do_reset("por", 1'b0);
    step(1'b0, 1'b0);
    chk("por2", 3'b000);

    // 10,10,3,10 with 4-cycle gaps: L L S L -> one MATCH on the 4th
    press("a1", 10, 1'b1, 1'b0); gap("a1", 4);
    press("a2", 10, 1'b1, 1'b0); gap("a2", 4);
    press("a3",  3, 1'b0, 1'b0); gap("a3", 4);
    press("a4", 10, 1'b1, 1'b1); gap("a4", 4);

    // Long threshold boundary: 7 cycles short, 8 cycles long
    do_reset("b", 1'b0);
    press("b7", 7, 1'b0, 1'b0); gap("b7", 4);
    press("b8", 8, 1'b1, 1'b0); gap("b8", 4);

    // 15 released cycles keep the history; L L S + L still matches
    do_reset("c", 1'b0);
    press("c1", 9, 1'b1, 1'b0); gap("c1", 4);
    press("c2", 9, 1'b1, 1'b0); gap("c2", 4);
    press("c3", 2, 1'b0, 1'b0); gap("c3", 15);
    press("c4", 9, 1'b1, 1'b1); gap("c4", 16);

    // 16 released cycles clear the history: L L S, timeout, L -> no match
    press("d1", 9, 1'b1, 1'b0); gap("d1", 4);
    press("d2", 9, 1'b1, 1'b0); gap("d2", 4);
    press("d3", 2, 1'b0, 1'b0); gap("d3", 16);
    press("d4", 9, 1'b1, 1'b0); gap("d4", 4);
    // Counting restarted at d4: d4 L, L, S, L -> match
    press("d5", 9, 1'b1, 1'b0); gap("d5", 4);
    press("d6", 2, 1'b0, 1'b0); gap("d6", 4);
    press("d7", 9, 1'b1, 1'b1); gap("d7", 4);

    // Overlap: L L S L L S L -> windows 1101 at 4th and 1101 again at 7th
    do_reset("e", 1'b0);
    press("e1", 9, 1'b1, 1'b0); gap("e1", 4);
    press("e2", 9, 1'b1, 1'b0); gap("e2", 4);
    press("e3", 2, 1'b0, 1'b0); gap("e3", 4);
    press("e4", 9, 1'b1, 1'b1); gap("e4", 4);
    press("e5", 9, 1'b1, 1'b0); gap("e5", 4);
    press("e6", 2, 1'b0, 1'b0); gap("e6", 4);
    press("e7", 9, 1'b1, 1'b1); gap("e7", 4);

    // Reset mid-hold discards the press; SYM was 1 before
    for (int i = 0; i < 5; i++) step(1'b1);
    chk("f_hold", 3'b010);
    do_reset("f", 1'b1);
    step(1'b0);
    chk("f_nopress", 3'b000);
    step(1'b0);
    chk("f_idle", 3'b000);
    press("f1", 10, 1'b1, 1'b0); gap("f1", 4);
    press("f2", 10, 1'b1, 1'b0); gap("f2", 4);
    press("f3",  3, 1'b0, 1'b0); gap("f3", 4);
    press("f4", 10, 1'b1, 1'b1); gap("f4", 4);

    // CLEAN already high out of reset: next 1 starts a press, 8 cycles -> long
    do_reset("g", 1'b1);
    press("g1", 8, 1'b1, 1'b0); gap("g1", 4);

    // Very long holds: duration saturates instead of wrapping
    do_reset("h", 1'b0);
    press("h300", 300, 1'b1, 1'b0); gap("h300", 4);
    press("h260", 260, 1'b1, 1'b0); gap("h260", 4);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
